// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/trap controller: next-PC selects,
// forwarding sources, trap FSM states and the register-hit helper.
package hazard_pkg;

  localparam logic [2:0] PCSEL_PC4   = 3'd0;
  localparam logic [2:0] PCSEL_CONBA = 3'd1;
  localparam logic [2:0] PCSEL_JUMP  = 3'd2;
  localparam logic [2:0] PCSEL_JR    = 3'd3;
  localparam logic [2:0] PCSEL_ILLOP = 3'd4;
  localparam logic [2:0] PCSEL_XADR  = 3'd5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Last SETTLE count value before a forced return to RUN (two SETTLE cycles).
  localparam logic [1:0] SETTLE_LAST = 2'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_TRAP   = 2'd1,
    ST_SETTLE = 2'd2
  } trap_state_e;

  function automatic logic reg_hit(input logic regwr, input logic [4:0] waddr,
                                   input logic [4:0] src);
    return regwr && (waddr != 5'd0) && (waddr == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline stage fields in, sequencing controls out. The slave modport is the
// controller's view; master is the pipeline's view.
interface hazard_ctrl_if;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        id_jump, id_jr, id_illegal;
  logic [31:0] id_pc_4;
  logic [4:0]  ex_rs, ex_rt;
  logic        ex_regwr, ex_memrd;
  logic [4:0]  ex_waddr;
  logic        ex_branch, ex_taken;
  logic        mem_regwr;
  logic [4:0]  mem_waddr;
  logic        wb_regwr;
  logic [4:0]  wb_waddr;
  logic        irq, pc_kernel;
  logic        pc_wr, if_id_wr, if_id_flush, id_ex_flush;
  logic [2:0]  pc_sel;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] epc;
  logic        trap_busy;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr, id_illegal, id_pc_4,
    input  ex_rs, ex_rt, ex_regwr, ex_memrd, ex_waddr, ex_branch, ex_taken,
    input  mem_regwr, mem_waddr, wb_regwr, wb_waddr, irq, pc_kernel,
    output pc_wr, if_id_wr, if_id_flush, id_ex_flush, pc_sel, fwd_a, fwd_b, epc, trap_busy
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr, id_illegal, id_pc_4,
    output ex_rs, ex_rt, ex_regwr, ex_memrd, ex_waddr, ex_branch, ex_taken,
    output mem_regwr, mem_waddr, wb_regwr, wb_waddr, irq, pc_kernel,
    input  pc_wr, if_id_wr, if_id_flush, id_ex_flush, pc_sel, fwd_a, fwd_b, epc, trap_busy
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Pure EX operand forwarding compare; slot 0 is the rs operand, slot 1 is rt.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic            mem_regwr,
  input  logic [4:0]      mem_waddr,
  input  logic            wb_regwr,
  input  logic [4:0]      wb_waddr,
  input  logic [1:0][4:0] ex_src,
  output logic [1:0][1:0] fwd_sel
);

  // The younger MEM result shadows an older WB write to the same register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      assign fwd_sel[gi] = reg_hit(mem_regwr, mem_waddr, ex_src[gi]) ? FWD_MEM :
                           reg_hit(wb_regwr,  wb_waddr,  ex_src[gi]) ? FWD_WB  : FWD_RF;
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS pipeline sequencer: stalls, flushes, next-PC select, forwarding
// and the interrupt/exception trap FSM. Define FORWARD_EN to enable EX forwarding.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

`ifdef FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  trap_state_e     state_q, state_d;
  logic            irq_pend_q, irq_pend_d;
  logic [31:0]     epc_q, epc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0][1:0] fwd_raw;

  logic ex_hit, mem_hit, wb_hit, jr_stall, stall, branch, trap_take, irq_take;
  logic pc_wr_c, if_id_wr_c, if_id_flush_c, id_ex_flush_c;
  logic [2:0] pc_sel_c;

  fwd_unit u_fwd (
    .mem_regwr (hz.mem_regwr),
    .mem_waddr (hz.mem_waddr),
    .wb_regwr  (hz.wb_regwr),
    .wb_waddr  (hz.wb_waddr),
    .ex_src    ({hz.ex_rt, hz.ex_rs}),
    .fwd_sel   (fwd_raw)
  );

  assign ex_hit  = (hz.id_use_rs && reg_hit(hz.ex_regwr, hz.ex_waddr, hz.id_rs)) ||
                   (hz.id_use_rt && reg_hit(hz.ex_regwr, hz.ex_waddr, hz.id_rt));
  assign mem_hit = (hz.id_use_rs && reg_hit(hz.mem_regwr, hz.mem_waddr, hz.id_rs)) ||
                   (hz.id_use_rt && reg_hit(hz.mem_regwr, hz.mem_waddr, hz.id_rt));
  assign wb_hit  = (hz.id_use_rs && reg_hit(hz.wb_regwr, hz.wb_waddr, hz.id_rs)) ||
                   (hz.id_use_rt && reg_hit(hz.wb_regwr, hz.wb_waddr, hz.id_rt));

  // jr resolves its target in ID, so no forwarding path reaches it.
  assign jr_stall = hz.id_jr && (reg_hit(hz.ex_regwr,  hz.ex_waddr,  hz.id_rs) ||
                                 reg_hit(hz.mem_regwr, hz.mem_waddr, hz.id_rs) ||
                                 reg_hit(hz.wb_regwr,  hz.wb_waddr,  hz.id_rs));
  assign stall = jr_stall || (FWD_ON ? (hz.ex_memrd && ex_hit) : (ex_hit || mem_hit || wb_hit));

  assign branch    = hz.ex_branch && hz.ex_taken;
  assign trap_take = (state_q == ST_RUN) && !branch &&
                     (hz.id_illegal || (irq_pend_q && !hz.pc_kernel));
  assign irq_take  = trap_take && !hz.id_illegal;

  always_comb begin
    pc_wr_c       = 1'b1;
    if_id_wr_c    = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    pc_sel_c      = PCSEL_PC4;
    if (state_q != ST_TRAP) begin
      if (branch) begin
        pc_sel_c      = PCSEL_CONBA;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end else if (trap_take) begin
        pc_sel_c      = hz.id_illegal ? PCSEL_XADR : PCSEL_ILLOP;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end else if (stall) begin
        pc_wr_c       = 1'b0;
        if_id_wr_c    = 1'b0;
        id_ex_flush_c = 1'b1;
      end else if (hz.id_jump) begin
        pc_sel_c      = PCSEL_JUMP;
        if_id_flush_c = 1'b1;
      end else if (hz.id_jr) begin
        pc_sel_c      = PCSEL_JR;
        if_id_flush_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    irq_pend_d = irq_pend_q || (hz.irq && (state_q == ST_RUN));
    if (irq_take) irq_pend_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trap_take) begin
          state_d = ST_TRAP;
          epc_d   = hz.id_pc_4;
        end
      end
      ST_TRAP: begin
        state_d = ST_SETTLE;
        cnt_d   = 2'd0;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 2'd1;
        if (hz.pc_kernel || (cnt_q == SETTLE_LAST)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      irq_pend_q <= 1'b0;
      epc_q      <= 32'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      epc_q      <= epc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Reset forces the idle control word straight from the pin, not through the flops.
  assign hz.pc_wr       = pc_wr_c || !reset;
  assign hz.if_id_wr    = if_id_wr_c || !reset;
  assign hz.if_id_flush = if_id_flush_c && reset;
  assign hz.id_ex_flush = id_ex_flush_c && reset;
  assign hz.pc_sel      = reset ? pc_sel_c : PCSEL_PC4;
  assign hz.fwd_a       = (reset && FWD_ON) ? fwd_raw[0] : FWD_RF;
  assign hz.fwd_b       = (reset && FWD_ON) ? fwd_raw[1] : FWD_RF;
  assign hz.epc         = epc_q;
  assign hz.trap_busy   = reset && (state_q != ST_RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random stage fields, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

`ifdef FORWARD_EN
  localparam bit TB_FWD = 1'b1;
`else
  localparam bit TB_FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: pending IRQ, captured return address, cycles since trap take (0 = running).
  bit          m_pend;
  logic [31:0] m_epc;
  int          m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes(input logic wr, input logic [4:0] wa, input logic [4:0] src);
    return wr && (wa != 5'd0) && (wa == src);
  endfunction

  task automatic drive_idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_jump = 0; hz.id_jr = 0; hz.id_illegal = 0; hz.id_pc_4 = '0;
    hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_regwr = 0; hz.ex_memrd = 0; hz.ex_waddr = '0;
    hz.ex_branch = 0; hz.ex_taken = 0; hz.mem_regwr = 0; hz.mem_waddr = '0;
    hz.wb_regwr = 0; hz.wb_waddr = '0; hz.irq = 0; hz.pc_kernel = 0;
  endtask

  task automatic drive_random();
    hz.id_rs = 5'($urandom_range(0, 3)); hz.id_rt = 5'($urandom_range(0, 3));
    hz.id_use_rs = 1'($urandom); hz.id_use_rt = 1'($urandom);
    hz.id_jump = ($urandom_range(0, 7) == 0); hz.id_jr = ($urandom_range(0, 5) == 0);
    hz.id_illegal = ($urandom_range(0, 15) == 0); hz.id_pc_4 = $urandom;
    hz.ex_rs = 5'($urandom_range(0, 3)); hz.ex_rt = 5'($urandom_range(0, 3));
    hz.ex_regwr = 1'($urandom); hz.ex_memrd = ($urandom_range(0, 2) == 0);
    hz.ex_waddr = 5'($urandom_range(0, 3));
    hz.ex_branch = ($urandom_range(0, 3) == 0); hz.ex_taken = 1'($urandom);
    hz.mem_regwr = 1'($urandom); hz.mem_waddr = 5'($urandom_range(0, 3));
    hz.wb_regwr = 1'($urandom); hz.wb_waddr = 5'($urandom_range(0, 3));
    hz.irq = ($urandom_range(0, 7) == 0); hz.pc_kernel = ($urandom_range(0, 3) == 0);
  endtask

  // Called at a negedge with inputs settled: check outputs, then advance the model past the posedge.
  task automatic step();
    bit br, take, irq_take, hit_ex, hit_mem, hit_wb, jrs, stl;
    bit e_pcwr, e_ifid, e_iff, e_idf, e_busy;
    int e_sel, e_fa, e_fb;
    #2;
    e_pcwr = 1; e_ifid = 1; e_iff = 0; e_idf = 0; e_sel = 0; e_fa = 0; e_fb = 0;
    e_busy = 0; take = 0; irq_take = 0;
    if (reset) begin
      e_busy = (m_since != 0);
      if (TB_FWD) begin
        e_fa = writes(hz.mem_regwr, hz.mem_waddr, hz.ex_rs) ? 1 :
               writes(hz.wb_regwr, hz.wb_waddr, hz.ex_rs) ? 2 : 0;
        e_fb = writes(hz.mem_regwr, hz.mem_waddr, hz.ex_rt) ? 1 :
               writes(hz.wb_regwr, hz.wb_waddr, hz.ex_rt) ? 2 : 0;
      end
      br = hz.ex_branch && hz.ex_taken;
      take = (m_since == 0) && !br && (hz.id_illegal || (m_pend && !hz.pc_kernel));
      irq_take = take && !hz.id_illegal;
      hit_ex  = (hz.id_use_rs && writes(hz.ex_regwr, hz.ex_waddr, hz.id_rs)) ||
                (hz.id_use_rt && writes(hz.ex_regwr, hz.ex_waddr, hz.id_rt));
      hit_mem = (hz.id_use_rs && writes(hz.mem_regwr, hz.mem_waddr, hz.id_rs)) ||
                (hz.id_use_rt && writes(hz.mem_regwr, hz.mem_waddr, hz.id_rt));
      hit_wb  = (hz.id_use_rs && writes(hz.wb_regwr, hz.wb_waddr, hz.id_rs)) ||
                (hz.id_use_rt && writes(hz.wb_regwr, hz.wb_waddr, hz.id_rt));
      jrs = hz.id_jr && (writes(hz.ex_regwr, hz.ex_waddr, hz.id_rs) ||
                         writes(hz.mem_regwr, hz.mem_waddr, hz.id_rs) ||
                         writes(hz.wb_regwr, hz.wb_waddr, hz.id_rs));
      stl = jrs || (TB_FWD ? (hz.ex_memrd && hit_ex) : (hit_ex || hit_mem || hit_wb));
      if (m_since == 1) begin
        // trap cycle: plain PC+4 fetch from the vector
      end else if (br) begin
        e_sel = 1; e_iff = 1; e_idf = 1;
      end else if (take) begin
        e_sel = hz.id_illegal ? 5 : 4; e_iff = 1; e_idf = 1;
      end else if (stl) begin
        e_pcwr = 0; e_ifid = 0; e_idf = 1;
      end else if (hz.id_jump) begin
        e_sel = 2; e_iff = 1;
      end else if (hz.id_jr) begin
        e_sel = 3; e_iff = 1;
      end
    end
    chk("pc_wr",       32'(hz.pc_wr),       32'(e_pcwr));
    chk("if_id_wr",    32'(hz.if_id_wr),    32'(e_ifid));
    chk("if_id_flush", 32'(hz.if_id_flush), 32'(e_iff));
    chk("id_ex_flush", 32'(hz.id_ex_flush), 32'(e_idf));
    chk("pc_sel",      32'(hz.pc_sel),      32'(e_sel));
    chk("fwd_a",       32'(hz.fwd_a),       32'(e_fa));
    chk("fwd_b",       32'(hz.fwd_b),       32'(e_fb));
    chk("trap_busy",   32'(hz.trap_busy),   32'(e_busy));
    chk("epc",         hz.epc,              m_epc);
    if (reset) begin
      if (take) m_epc = hz.id_pc_4;
      if (irq_take) m_pend = 0;
      else if (hz.irq && m_since == 0) m_pend = 1;
      if (take) m_since = 1;
      else if (m_since == 1) m_since = 2;
      else if (m_since >= 2) m_since = (hz.pc_kernel || m_since == 3) ? 0 : m_since + 1;
    end else begin
      m_pend = 0; m_epc = '0; m_since = 0;
    end
    @(negedge clk);
  endtask

  int lu_stalls;

  initial begin
    m_pend = 0; m_epc = '0; m_since = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    hz.ex_branch = 1; hz.ex_taken = 1; hz.id_illegal = 1;
    #1;
    chk("rst_pc_sel", 32'(hz.pc_sel), 32'(PCSEL_PC4));
    chk("rst_flush", 32'(hz.id_ex_flush), 32'd0);
    step();
    drive_idle();
    reset = 1'b1;
    step();

    // Load-use: lw $8 moves EX->MEM->WB while add $9,$8,$8 waits in ID.
    lu_stalls = 0;
    hz.id_rs = 5'd8; hz.id_rt = 5'd8; hz.id_use_rs = 1; hz.id_use_rt = 1;
    for (int c = 0; c < 4; c++) begin
      hz.ex_regwr = (c == 0); hz.ex_memrd = (c == 0); hz.ex_waddr = (c == 0) ? 5'd8 : 5'd0;
      hz.mem_regwr = (c == 1); hz.mem_waddr = (c == 1) ? 5'd8 : 5'd0;
      hz.wb_regwr = (c == 2); hz.wb_waddr = (c == 2) ? 5'd8 : 5'd0;
      #1;
      if (!hz.pc_wr) lu_stalls++;
      step();
    end
    chk("lu_bubbles", 32'(lu_stalls), TB_FWD ? 32'd1 : 32'd3);
    $display("load-use: %0d stall cycles", lu_stalls);

    // ALU chain on $5: MEM producer, then WB producer, then a $0 destination.
    drive_idle();
    hz.ex_rs = 5'd5; hz.mem_regwr = 1; hz.mem_waddr = 5'd5;
    #1; chk("chain_mem", 32'(hz.fwd_a), TB_FWD ? 32'd1 : 32'd0); step();
    hz.mem_regwr = 0; hz.wb_regwr = 1; hz.wb_waddr = 5'd5;
    #1; chk("chain_wb", 32'(hz.fwd_a), TB_FWD ? 32'd2 : 32'd0); step();
    hz.ex_rs = 5'd0; hz.mem_regwr = 1; hz.mem_waddr = 5'd0; hz.wb_waddr = 5'd0;
    #1; chk("chain_r0", 32'(hz.fwd_a), 32'd0); step();
    $display("alu chain: fwd_a checked for MEM, WB and $0");

    // Taken beq in EX beats jr in ID.
    drive_idle();
    hz.ex_branch = 1; hz.ex_taken = 1; hz.id_jr = 1; hz.id_rs = 5'd31;
    #1; chk("br_sel", 32'(hz.pc_sel), 32'(PCSEL_CONBA)); step();
    $display("branch vs jr: pc_sel=%0d", hz.pc_sel);

    // One-cycle IRQ pulse in user mode.
    drive_idle();
    hz.id_pc_4 = 32'h24; hz.irq = 1; step();
    hz.irq = 0;
    #1; chk("irq_sel", 32'(hz.pc_sel), 32'(PCSEL_ILLOP)); step();
    hz.pc_kernel = 1;
    #1; chk("irq_epc", hz.epc, 32'h24); chk("irq_busy1", 32'(hz.trap_busy), 32'd1); step();
    #1; chk("irq_busy2", 32'(hz.trap_busy), 32'd1); step();
    hz.pc_kernel = 0;
    #1; chk("irq_done", 32'(hz.trap_busy), 32'd0); chk("irq_once", 32'(hz.pc_sel), 32'd0); step();
    $display("irq: epc=0x%0h", hz.epc);

    // Illegal opcode while an IRQ is pending: exception first, IRQ back in user mode.
    hz.irq = 1; step();
    hz.irq = 0; hz.id_illegal = 1; hz.id_pc_4 = 32'h40;
    #1; chk("ill_sel", 32'(hz.pc_sel), 32'(PCSEL_XADR)); step();
    hz.id_illegal = 0; hz.pc_kernel = 1; step(); step();
    #1; chk("ill_kernel", 32'(hz.pc_sel), 32'd0); step();
    hz.pc_kernel = 0;
    #1; chk("ill_irq_late", 32'(hz.pc_sel), 32'(PCSEL_ILLOP)); step();
    hz.pc_kernel = 1; step(); step();
    $display("illegal+irq: epc=0x%0h", hz.epc);

    // Reset pulled low during SETTLE with an IRQ still pending.
    hz.pc_kernel = 0; hz.irq = 1; step();
    hz.irq = 0; hz.id_illegal = 1; hz.id_pc_4 = 32'h80; step();
    hz.id_illegal = 0; step();
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(hz.trap_busy), 32'd0);
    chk("arst_pc_wr", 32'(hz.pc_wr), 32'd1);
    chk("arst_epc", hz.epc, 32'd0);
    m_pend = 0; m_epc = '0; m_since = 0;
    @(negedge clk);
    step();
    reset = 1'b1;
    #1; chk("arst_no_irq", 32'(hz.pc_sel), 32'd0); step();
    $display("reset in settle: state cleared");

    // Random stage fields.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 250; i++) begin
        drive_random();
        step();
      end
      $display("random batch %0d: %0d comparisons so far", b, n_chk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
